// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the multi-input pipe mux.
// Bus-slice macros live alongside the package so every file that imports it can use them.
`define MUX_PIPE_BUS_W(n, w) ((n) * (w))
`define MUX_PIPE_SLICE(idx, w) ((idx) * (w)) +: (w)

package mux_pipe_pkg;

    localparam int RR_MODE_RR    = 1;
    localparam int RR_MODE_FIXED = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Per-channel circular-buffer FIFO; write visible on deq one cycle after push, no empty bypass.
// Backpressure: enq_rdy drops when count reaches DEPTH and is held low during reset.
module pipe_fifo
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq_ena,
    input  logic [WIDTH-1:0] enq_v,
    output logic             enq_rdy,
    input  logic             deq_ena,
    output logic             deq_rdy,
    output logic [WIDTH-1:0] deq_v,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign enq_rdy = !RST && (count != CNT_W'(DEPTH));
    assign deq_rdy = (count != '0);
    assign deq_v   = mem[rd_ptr];
    assign push    = enq_ena && enq_rdy;
    assign pop     = deq_ena && deq_rdy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= enq_v;
    end

    // Enqueueing into a full FIFO silently drops the word; flag it in simulation.
    assert property (@(posedge CLK) disable iff (RST) !(enq_ena && !enq_rdy));

endmodule

// File: rtl/mux_pipe_arb.sv
// Merges NUM_IN buffered enq pipes onto one registered out pipe with a source-channel tag; 2-cycle min latency.
// Backpressure: out_enq_rdy low holds the output register; per-channel FIFOs fill and drop in_enq_rdy.
module mux_pipe_arb
    import mux_pipe_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int WIDTH   = 128,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = RR_MODE_RR,
    parameter int CHAN_W  = clog2(NUM_IN)
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [NUM_IN-1:0]                         in_enq_ena,
    input  logic [`MUX_PIPE_BUS_W(NUM_IN, WIDTH)-1:0] in_enq_v,
    output logic [NUM_IN-1:0]                         in_enq_rdy,
    output logic                                      out_enq_ena,
    output logic [WIDTH-1:0]                          out_enq_v,
    output logic [CHAN_W-1:0]                         out_enq_chan,
    input  logic                                      out_enq_rdy
);

    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [NUM_IN-1:0] nonempty;
    logic [NUM_IN-1:0] deq_ena;
    logic [WIDTH-1:0]  head  [NUM_IN];
    logic [CNT_W-1:0]  count [NUM_IN];

    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [CHAN_W-1:0] out_chan;
    logic [CHAN_W-1:0] last_grant;
    logic [CHAN_W-1:0] grant;
    logic              take;
    logic              load;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
        pipe_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .CLK     (CLK),
            .RST     (RST),
            .enq_ena (in_enq_ena[i]),
            .enq_v   (in_enq_v[`MUX_PIPE_SLICE(i, WIDTH)]),
            .enq_rdy (in_enq_rdy[i]),
            .deq_ena (deq_ena[i]),
            .deq_rdy (nonempty[i]),
            .deq_v   (head[i]),
            .count   (count[i])
        );

        assert property (@(posedge CLK) disable iff (RST) count[i] <= CNT_W'(DEPTH));
    end

    // Scan runs highest-to-lowest so the last hit is the first candidate in priority order.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        if (RR_MODE == RR_MODE_RR) begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                idx = (int'(last_grant) + 1 + k) % NUM_IN;
                if (nonempty[CHAN_W'(idx)]) grant = CHAN_W'(idx);
            end
        end else begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (nonempty[k]) grant = CHAN_W'(k);
            end
        end
    end

    assign take = out_valid && out_enq_rdy;
    assign load = !RST && (!out_valid || take) && (|nonempty);

    always_comb begin
        deq_ena = '0;
        if (load) deq_ena[grant] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CHAN_W'(NUM_IN - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= head[grant];
            out_chan  <= grant;
            if (RR_MODE == RR_MODE_RR) last_grant <= grant;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

    // Held word is being discarded by reset, so never strobe it out in the reset cycle.
    assign out_enq_ena  = take && !RST;
    assign out_enq_v    = out_data;
    assign out_enq_chan = out_chan;

endmodule

// File: tb/tb_mux_pipe_arb.sv
module tb_mux_pipe_arb;

    typedef logic [127:0] word_t;

    logic        clk;
    logic        rst;
    logic [1:0]  ena  [2];
    logic [255:0] vbus;
    logic        out_rdy;
    logic [1:0]  rdy  [2];
    logic        oena [2];
    word_t       ov   [2];
    logic [0:0]  oc   [2];

    int tests;
    int failed;
    int cyc;

    // Reference model: index 0 = round-robin DUT, 1 = fixed-priority DUT.
    word_t mq [4][$];
    bit    m_ov [2];
    word_t m_od [2];
    int    m_oc [2];
    int    m_lg [2];
    word_t log_d [2][$];
    int    log_c [2][$];
    int    log_t [2][$];

    mux_pipe_arb #(.NUM_IN(2), .WIDTH(128), .DEPTH(4), .RR_MODE(1)) dut_rr (
        .CLK(clk), .RST(rst),
        .in_enq_ena(ena[0]), .in_enq_v(vbus), .in_enq_rdy(rdy[0]),
        .out_enq_ena(oena[0]), .out_enq_v(ov[0]), .out_enq_chan(oc[0]),
        .out_enq_rdy(out_rdy)
    );

    mux_pipe_arb #(.NUM_IN(2), .WIDTH(128), .DEPTH(4), .RR_MODE(0)) dut_fx (
        .CLK(clk), .RST(rst),
        .in_enq_ena(ena[1]), .in_enq_v(vbus), .in_enq_rdy(rdy[1]),
        .out_enq_ena(oena[1]), .out_enq_v(ov[1]), .out_enq_chan(oc[1]),
        .out_enq_rdy(out_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) mq[d*2+ch].delete();
            m_ov[d] = 1'b0;
            m_od[d] = '0;
            m_oc[d] = 0;
            m_lg[d] = 1;
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            log_d[d].delete();
            log_c[d].delete();
            log_t[d].delete();
        end
    endtask

    // One clock cycle: drive, check outputs at negedge, advance the model at posedge.
    task automatic step(input bit r, input bit [1:0] want, input word_t d0, input word_t d1, input bit ordy);
        bit exp_rdy [2][2];
        bit take;
        int g;
        int c;
        rst     = r;
        out_rdy = ordy;
        vbus    = {d1, d0};
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                exp_rdy[d][ch] = !r && (mq[d*2+ch].size() != 4);
                ena[d][ch]     = want[ch] && exp_rdy[d][ch];
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rdy d%0d c%0d", d, cyc), word_t'(rdy[d]), word_t'({exp_rdy[d][1], exp_rdy[d][0]}));
            chk($sformatf("ena d%0d c%0d", d, cyc), word_t'(oena[d]), word_t'(m_ov[d] && ordy && !r));
            chk($sformatf("data d%0d c%0d", d, cyc), ov[d], m_od[d]);
            chk($sformatf("chan d%0d c%0d", d, cyc), word_t'(oc[d]), word_t'(m_oc[d]));
            if (oena[d] === 1'b1) begin
                log_d[d].push_back(ov[d]);
                log_c[d].push_back(int'(oc[d]));
                log_t[d].push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                take = m_ov[d] && ordy;
                g = -1;
                if (!m_ov[d] || take) begin
                    for (int k = 1; k <= 2; k++) begin
                        c = (d == 0) ? (m_lg[d] + k) % 2 : k - 1;
                        if (g < 0 && mq[d*2+c].size() > 0) g = c;
                    end
                end
                if (g >= 0) begin
                    m_od[d] = mq[d*2+g].pop_front();
                    m_oc[d] = g;
                    m_ov[d] = 1'b1;
                    if (d == 0) m_lg[d] = g;
                end else if (take) begin
                    m_ov[d] = 1'b0;
                end
                for (int ch = 0; ch < 2; ch++) begin
                    if (ena[d][ch]) mq[d*2+ch].push_back(ch == 0 ? d0 : d1);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, ordy);
    endtask

    initial begin
        int push_cyc;
        tests   = 0;
        failed  = 0;
        cyc     = 0;
        rst     = 1'b1;
        ena[0]  = 2'b00;
        ena[1]  = 2'b00;
        vbus    = '0;
        out_rdy = 1'b1;
        model_reset();
        clear_logs();
        @(posedge clk);
        #1;

        // Reset held three cycles, then idle.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, '0, '0, 1'b1);
        idle(5, 1'b1);

        // Single word on channel 1.
        clear_logs();
        idle(10 - cyc > 0 ? 10 - cyc : 0, 1'b1);
        push_cyc = cyc;
        step(1'b0, 2'b10, '0, 128'h0000_0001_0000_0002, 1'b1);
        idle(6, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("single count d%0d", d), word_t'(log_d[d].size()), 1);
            if (log_d[d].size() > 0) begin
                chk($sformatf("single data d%0d", d), log_d[d][0], 128'h0000_0001_0000_0002);
                chk($sformatf("single chan d%0d", d), word_t'(log_c[d][0]), 1);
                chk($sformatf("single time d%0d", d), word_t'(log_t[d][0]), word_t'(push_cyc + 2));
            end
        end

        // Both channels pushing every cycle.
        step(1'b1, 2'b00, '0, '0, 1'b1);
        clear_logs();
        for (int k = 0; k < 8; k++) step(1'b0, 2'b11, word_t'(8'hA0 + k), word_t'(8'hB0 + k), 1'b1);
        idle(14, 1'b1);
        chk("rr count", word_t'(log_d[0].size() >= 4), 1);
        if (log_d[0].size() >= 4) begin
            chk("rr w0", {log_d[0][0][119:0], 8'(log_c[0][0])}, {120'hA0, 8'd0});
            chk("rr w1", {log_d[0][1][119:0], 8'(log_c[0][1])}, {120'hB0, 8'd1});
            chk("rr w2", {log_d[0][2][119:0], 8'(log_c[0][2])}, {120'hA1, 8'd0});
            chk("rr w3", {log_d[0][3][119:0], 8'(log_c[0][3])}, {120'hB1, 8'd1});
        end
        chk("fx count", word_t'(log_d[1].size()), 12);
        if (log_d[1].size() == 12) begin
            chk("fx a7", {log_d[1][7][119:0], 8'(log_c[1][7])}, {120'hA7, 8'd0});
            chk("fx b0", {log_d[1][8][119:0], 8'(log_c[1][8])}, {120'hB0, 8'd1});
            chk("fx b3", {log_d[1][11][119:0], 8'(log_c[1][11])}, {120'hB3, 8'd1});
        end

        // Backpressure: five words into ch0 with the output stalled, then release.
        step(1'b1, 2'b00, '0, '0, 1'b1);
        clear_logs();
        for (int k = 0; k < 5; k++) step(1'b0, 2'b01, word_t'(12'h100 + k), '0, 1'b0);
        idle(2, 1'b0);
        for (int d = 0; d < 2; d++) chk($sformatf("bp held d%0d", d), word_t'(log_d[d].size()), 0);
        idle(8, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("bp count d%0d", d), word_t'(log_d[d].size()), 5);
            if (log_d[d].size() == 5) begin
                for (int k = 0; k < 5; k++) begin
                    chk($sformatf("bp w%0d d%0d", k, d), log_d[d][k], word_t'(12'h100 + k));
                    chk($sformatf("bp t%0d d%0d", k, d), word_t'(log_t[d][k]), word_t'(log_t[d][0] + k));
                end
            end
        end

        // Reset while a word is held and three are buffered.
        step(1'b1, 2'b00, '0, '0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 2'b01, word_t'(12'h200 + k), '0, 1'b0);
        clear_logs();
        step(1'b1, 2'b00, '0, '0, 1'b1);
        idle(6, 1'b1);
        for (int d = 0; d < 2; d++) chk($sformatf("rst stale d%0d", d), word_t'(log_d[d].size()), 0);

        // Randomized traffic with occasional reset and stalls.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3) != 0);
        end
        idle(12, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mux_pipe_arb.md
Name: mux_pipe_arb

Overview:
- Parametrised successor to the two-input combinational pipe mux: merges NUM_IN enq pipes onto one out pipe.
- Adds per-input buffering, fair or fixed-priority arbitration, a registered output stage, and a source-channel tag.
- Sits between the indication M2P/printf sources and the top-level indication pipe.
- Removes the combinational out RDY -> in RDY path.

Parameters:
- NUM_IN, 2, number of input channels (>=2); channel 0 takes the former forward role.
- WIDTH, 128, pipe payload width in bits.
- DEPTH, 4, per-channel FIFO entries (power of 2, >=2).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- CHAN_W, clog2(NUM_IN), derived; not overridden.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- in$enq__ENA  in  NUM_IN  per-channel enqueue strobe.
- in$enq$v  in  NUM_IN*WIDTH  payloads; channel i occupies [i*WIDTH +: WIDTH].
- in$enq__RDY  out  NUM_IN  per-channel can-accept.
- out$enq__ENA  out  1  transfer on the out pipe this cycle.
- out$enq$v  out  WIDTH  output payload.
- out$enq$chan  out  CHAN_W  source channel of the current payload.
- out$enq__RDY  in  1  downstream can accept.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While RST=1 and on the first cycle after it:
  - all FIFO counts = 0; out_valid = 0; out$enq$v = 0; out$enq$chan = 0.
  - in$enq__RDY = 0 while RST is high, all-ones after.
  - RR pointer last_grant = NUM_IN-1, so channel 0 wins the first RR tie.
- Reset mid-operation discards all buffered and held data. No output strobe appears in the reset cycle.
- Input side:
  - in$enq__RDY[i] = !RST & (count_i != DEPTH); a function of registers only.
  - A push occurs when in$enq__ENA[i] & in$enq__RDY[i].
  - ENA while not RDY is a protocol violation: the data is dropped, FIFO state is unchanged, and a simulation-only assertion fires.
- FIFO: circular buffer with read/write pointers of clog2(DEPTH) bits that wrap naturally, and a count of clog2(DEPTH)+1 bits.
  - There is no empty bypass.
  - Push and pop in the same cycle leave count unchanged.
- Output stage: registers out_valid, out_data, out_chan.
  - take = out_valid & out$enq__RDY.
  - out$enq__ENA = take (combinational from out_valid and out$enq__RDY only).
  - load = (!out_valid | take) & any FIFO non-empty. On load: pop the granted FIFO, out_data <= its head, out_chan <= grant, out_valid <= 1.
  - take & !load -> out_valid <= 0.
  - Full throughput is 1 word/cycle while data is available and out$enq__RDY=1.
- Latency: push in cycle N -> FIFO non-empty at N+1 -> loaded at the end of N+1 -> out$enq__ENA possible in N+2. Minimum latency is 2 cycles.
- Arbitration, evaluated only when load is asserted:
  - RR_MODE=1: the first non-empty channel scanning from (last_grant+1) mod NUM_IN upward with wrap. last_grant updates only on load.
  - RR_MODE=0: the lowest-index non-empty channel. last_grant is unused.
- Ordering: per-channel order is preserved; no cross-channel ordering is guaranteed.
- Backpressure: when out$enq__RDY=0, out_valid holds and the output registers are stable. FIFOs fill, and in$enq__RDY[i] drops at count_i == DEPTH.
- Simultaneous events: a push into a FIFO being popped in the same cycle is accepted whenever RDY was high at the start of the cycle.

Decomposition:
- Package mux_pipe_pkg:
  - mode constants RR_MODE_RR=1 and RR_MODE_FIXED=0.
  - a clog2 function.
  - helper macros for the width of a channel-indexed payload slice.
- Sub-module pipe_fifo (WIDTH, DEPTH): enq ENA/RDY/v, deq ENA/RDY/v, count output; instantiated NUM_IN times by generate.
- Arbiter and output stage stay in mux_pipe_arb.

Test Plan:
- Reset/idle: hold RST 3 cycles, release, no ENA -> in$enq__RDY=2'b11, out$enq__ENA=0, out$enq$v=0 every cycle.
- Single word: NUM_IN=2, push 128'h0000_0001_0000_0002 on ch1 at cycle 10, out$enq__RDY=1 -> out$enq__ENA=1 at cycle 12 with that value and chan=1; exactly one transfer.
- Round-robin fairness: RR_MODE=1, both channels push every cycle (ch0 value 0xA0+k, ch1 value 0xB0+k), RDY=1 -> outputs alternate chan 0,1,0,1, starting with ch0 0xA0; per-channel order intact.
- Fixed priority: RR_MODE=0, same stimulus -> only ch0 words emerge while ch0 is non-empty; ch1 FIFO reaches 4 and in$enq__RDY[1]=0; ch1 drains in order once ch0 stops.
- Backpressure/full: out$enq__RDY=0, push 5 words into ch0 (DEPTH=4) -> output holds word 0, 4 words buffered, in$enq__RDY[0]=0 after the 5th push; raise RDY -> words 0..4 emerge on 5 consecutive cycles.
- Reset mid-operation: with 3 words buffered and out_valid=1, assert RST 1 cycle -> no ENA in that cycle, all counts 0, and no stale word appears after release.
